// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU instruction and data request/response ports onto a single AXI4 master.
// At most one read may be outstanding per source, and one write may be outstanding.
module cpu_axi_bridge #(
    parameter logic [3:0] DATA_ID = 4'd1,
    parameter logic [3:0] INST_ID = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic {AR_IDLE = 1'b0, AR_SEND = 1'b1} ar_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_RESP = 2'd2} w_state_t;

    ar_state_t   ar_state_r, ar_state_s;
    w_state_t    w_state_r, w_state_s;
    logic        inst_rd_pend_r, data_rd_pend_r;
    logic [3:0]  arid_r;
    logic [31:0] araddr_r;
    logic [2:0]  arsize_r;
    logic [31:0] awaddr_r, wdata_r;
    logic [2:0]  awsize_r;
    logic [3:0]  wstrb_r;
    logic        awvalid_r, wvalid_r;
    logic        data_rd_acc_s, inst_rd_acc_s, data_wr_acc_s;
    logic        r_inst_s, r_data_s, b_done_s;

    // Request acceptance and response decode; data reads win over instruction reads.
    always_comb begin
        data_rd_acc_s = ~reset & data_req & ~data_wr & (ar_state_r == AR_IDLE)
                        & ~data_rd_pend_r & (w_state_r == W_IDLE);
        inst_rd_acc_s = ~reset & inst_req & (ar_state_r == AR_IDLE)
                        & ~inst_rd_pend_r & ~data_rd_acc_s;
        data_wr_acc_s = ~reset & data_req & data_wr & (w_state_r == W_IDLE) & ~data_rd_pend_r
                        & ~((ar_state_r == AR_SEND) & (arid_r == DATA_ID));
        r_inst_s      = ~reset & rvalid & (rid == INST_ID);
        r_data_s      = ~reset & rvalid & (rid == DATA_ID);
        b_done_s      = ~reset & (w_state_r == W_RESP) & bvalid;
    end

    // AR next-state logic.
    always_comb begin
        ar_state_s = ar_state_r;
        case (ar_state_r)
            AR_IDLE: begin
                if (data_rd_acc_s || inst_rd_acc_s) ar_state_s = AR_SEND;
                else                                ar_state_s = AR_IDLE;
            end
            AR_SEND: begin
                if (arready) ar_state_s = AR_IDLE;
                else         ar_state_s = AR_SEND;
            end
            default: ar_state_s = AR_IDLE;
        endcase
    end

    // W next-state logic; address and data handshakes may finish in any order.
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (data_wr_acc_s) w_state_s = W_SEND;
                else               w_state_s = W_IDLE;
            end
            W_SEND: begin
                if ((~awvalid_r | awready) & (~wvalid_r | wready)) w_state_s = W_RESP;
                else                                               w_state_s = W_SEND;
            end
            W_RESP: begin
                if (bvalid) w_state_s = W_IDLE;
                else        w_state_s = W_RESP;
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state_r <= AR_IDLE;
            w_state_r  <= W_IDLE;
        end else begin
            ar_state_r <= ar_state_s;
            w_state_r  <= w_state_s;
        end
    end

    // Read pending flags; acceptance needs a clear flag, so set and clear never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_rd_pend_r <= 1'b0;
            data_rd_pend_r <= 1'b0;
        end else begin
            if (inst_rd_acc_s)   inst_rd_pend_r <= 1'b1;
            else if (r_inst_s)   inst_rd_pend_r <= 1'b0;
            if (data_rd_acc_s)   data_rd_pend_r <= 1'b1;
            else if (r_data_s)   data_rd_pend_r <= 1'b0;
        end
    end

    // AR payload, held stable while AR_SEND waits for arready.
    always_ff @(posedge clk) begin
        if (reset) begin
            arid_r   <= 4'd0;
            araddr_r <= 32'd0;
            arsize_r <= 3'd0;
        end else if (data_rd_acc_s) begin
            arid_r   <= DATA_ID;
            araddr_r <= data_addr;
            arsize_r <= {1'b0, data_size};
        end else if (inst_rd_acc_s) begin
            arid_r   <= INST_ID;
            araddr_r <= inst_addr;
            arsize_r <= 3'd2;
        end
    end

    // AW/W payload and independent valid flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            awaddr_r  <= 32'd0;
            awsize_r  <= 3'd0;
            wstrb_r   <= 4'd0;
            wdata_r   <= 32'd0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
        end else if (data_wr_acc_s) begin
            awaddr_r  <= data_addr;
            awsize_r  <= {1'b0, data_size};
            wstrb_r   <= data_wstrb;
            wdata_r   <= data_wdata;
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
        end else begin
            awvalid_r <= awvalid_r & ~awready;
            wvalid_r  <= wvalid_r & ~wready;
        end
    end

    assign inst_addr_ok = inst_rd_acc_s;
    assign data_addr_ok = data_rd_acc_s | data_wr_acc_s;
    assign inst_data_ok = r_inst_s;
    assign inst_rdata   = rdata;
    assign data_data_ok = r_data_s | b_done_s;
    assign data_rdata   = rdata;

    assign arid    = arid_r;
    assign araddr  = araddr_r;
    assign arlen   = 8'd0;
    assign arsize  = arsize_r;
    assign arburst = 2'b01;
    assign arlock  = 1'b0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (ar_state_r == AR_SEND);
    assign rready  = 1'b1;

    assign awid    = DATA_ID;
    assign awaddr  = awaddr_r;
    assign awlen   = 8'd0;
    assign awsize  = awsize_r;
    assign awburst = 2'b01;
    assign awlock  = 1'b0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = awvalid_r;
    assign wid     = DATA_ID;
    assign wdata   = wdata_r;
    assign wstrb   = wstrb_r;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_r;
    assign bready  = (w_state_r == W_RESP);

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed, table-driven bench for cpu_axi_bridge: one record per clock cycle plus
// hand-written sequences for concurrent traffic and reset in the middle of a write.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        bvalid, bready;

    cpu_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwr;
        logic [1:0]  dsize;
        logic [3:0]  dstrb;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        arrdy;
        logic        rv;
        logic [3:0]  rid;
        logic [31:0] rd;
        logic        awrdy;
        logic        wrdy;
        logic        bv;
        logic [7:0]  ef;   // {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, arvalid, awvalid, wvalid, bready}
        logic [31:0] ea;   // expected araddr
        logic [3:0]  ei;   // expected arid
    } vec_t;

    vec_t tbl[$];
    vec_t v;
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t idle_v();
        vec_t r;
        r.rst = 1'b0; r.ireq = 1'b0; r.iaddr = 32'd0; r.dreq = 1'b0; r.dwr = 1'b0;
        r.dsize = 2'd2; r.dstrb = 4'd0; r.daddr = 32'd0; r.dwdata = 32'd0;
        r.arrdy = 1'b0; r.rv = 1'b0; r.rid = 4'd0; r.rd = 32'd0;
        r.awrdy = 1'b0; r.wrdy = 1'b0; r.bv = 1'b0;
        r.ef = 8'd0; r.ea = 32'd0; r.ei = 4'd0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        @(negedge clk);
        reset = x.rst; inst_req = x.ireq; inst_addr = x.iaddr;
        data_req = x.dreq; data_wr = x.dwr; data_size = x.dsize; data_wstrb = x.dstrb;
        data_addr = x.daddr; data_wdata = x.dwdata; arready = x.arrdy;
        rvalid = x.rv; rid = x.rid; rdata = x.rd;
        awready = x.awrdy; wready = x.wrdy; bvalid = x.bv;
        #1;
    endtask

    task automatic chk_flags(input string name, input logic [7:0] exp);
        chk(name, {24'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
                   arvalid, awvalid, wvalid, bready}, {24'd0, exp});
    endtask

    initial begin
        // r0: reset held with requests and a response present
        v = idle_v(); v.rst = 1'b1; v.ireq = 1'b1; v.iaddr = 32'h1C00_0000; v.dreq = 1'b1; v.daddr = 32'h100;
        v.rv = 1'b1; v.rd = 32'hDEAD_BEEF; tbl.push_back(v);
        // single instruction read
        v = idle_v(); v.ireq = 1'b1; v.iaddr = 32'h1C00_0000; v.arrdy = 1'b1; v.ef = 8'b1000_0000; tbl.push_back(v);
        v = idle_v(); v.arrdy = 1'b1; v.ef = 8'b0000_1000; v.ea = 32'h1C00_0000; tbl.push_back(v);
        v = idle_v(); v.arrdy = 1'b1; v.ea = 32'h1C00_0000; tbl.push_back(v);
        v = idle_v(); v.rv = 1'b1; v.rid = 4'd0; v.rd = 32'h0280_0C0C; v.ef = 8'b0010_0000; v.ea = 32'h1C00_0000; tbl.push_back(v);
        // conflict: data read wins, inst accepted once AR is idle again
        v = idle_v(); v.ireq = 1'b1; v.iaddr = 32'h1C00_0004; v.dreq = 1'b1; v.daddr = 32'h100;
        v.ef = 8'b0100_0000; v.ea = 32'h1C00_0000; tbl.push_back(v);
        v = idle_v(); v.ireq = 1'b1; v.iaddr = 32'h1C00_0004; v.ef = 8'b0000_1000; v.ea = 32'h100; v.ei = 4'd1; tbl.push_back(v);
        v = idle_v(); v.ireq = 1'b1; v.iaddr = 32'h1C00_0004; v.arrdy = 1'b1; v.ef = 8'b0000_1000; v.ea = 32'h100; v.ei = 4'd1; tbl.push_back(v);
        v = idle_v(); v.ireq = 1'b1; v.iaddr = 32'h1C00_0004; v.arrdy = 1'b1; v.ef = 8'b1000_0000; v.ea = 32'h100; v.ei = 4'd1; tbl.push_back(v);
        v = idle_v(); v.arrdy = 1'b1; v.ef = 8'b0000_1000; v.ea = 32'h1C00_0004; tbl.push_back(v);
        // out-of-order return; pending flags block new requests from both sources
        v = idle_v(); v.ireq = 1'b1; v.iaddr = 32'h1C00_0008; v.dreq = 1'b1; v.daddr = 32'h104;
        v.rv = 1'b1; v.rid = 4'd0; v.rd = 32'h1111_1111; v.ef = 8'b0010_0000; v.ea = 32'h1C00_0004; tbl.push_back(v);
        v = idle_v(); v.dreq = 1'b1; v.daddr = 32'h104; v.rv = 1'b1; v.rid = 4'd1; v.rd = 32'h2222_2222;
        v.ef = 8'b0001_0000; v.ea = 32'h1C00_0004; tbl.push_back(v);
        v = idle_v(); v.rv = 1'b1; v.rid = 4'd5; v.rd = 32'h0BAD_F00D; v.ea = 32'h1C00_0004; tbl.push_back(v);
        // byte store with late awready, then RAW-ordered read
        v = idle_v(); v.dreq = 1'b1; v.dwr = 1'b1; v.dsize = 2'd0; v.dstrb = 4'h4; v.daddr = 32'h203;
        v.dwdata = 32'h00AB_0000; v.wrdy = 1'b1; v.ef = 8'b0100_0000; v.ea = 32'h1C00_0004; tbl.push_back(v);
        v = idle_v(); v.wrdy = 1'b1; v.ef = 8'b0000_0110; v.ea = 32'h1C00_0004; tbl.push_back(v);
        v = idle_v(); v.dreq = 1'b1; v.daddr = 32'h300; v.ef = 8'b0000_0100; v.ea = 32'h1C00_0004; tbl.push_back(v);
        v = idle_v(); v.dreq = 1'b1; v.daddr = 32'h300; v.awrdy = 1'b1; v.ef = 8'b0000_0100; v.ea = 32'h1C00_0004; tbl.push_back(v);
        v = idle_v(); v.dreq = 1'b1; v.daddr = 32'h300; v.ef = 8'b0000_0001; v.ea = 32'h1C00_0004; tbl.push_back(v);
        v = idle_v(); v.dreq = 1'b1; v.daddr = 32'h300; v.bv = 1'b1; v.ef = 8'b0001_0001; v.ea = 32'h1C00_0004; tbl.push_back(v);
        v = idle_v(); v.dreq = 1'b1; v.daddr = 32'h300; v.ef = 8'b0100_0000; v.ea = 32'h1C00_0004; tbl.push_back(v);
        v = idle_v(); v.arrdy = 1'b1; v.ef = 8'b0000_1000; v.ea = 32'h300; v.ei = 4'd1; tbl.push_back(v);
        v = idle_v(); v.rv = 1'b1; v.rid = 4'd1; v.rd = 32'h3333_3333; v.ef = 8'b0001_0000; v.ea = 32'h300; v.ei = 4'd1; tbl.push_back(v);

        reset = 1'b1;
        v = idle_v(); v.rst = 1'b1;
        apply(v);
        apply(v);

        foreach (tbl[i]) begin
            apply(tbl[i]);
            chk($sformatf("v%0d flags", i), {24'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
                                             arvalid, awvalid, wvalid, bready}, {24'd0, tbl[i].ef});
            chk($sformatf("v%0d araddr", i), araddr, tbl[i].ea);
            chk($sformatf("v%0d arid", i), {28'd0, arid}, {28'd0, tbl[i].ei});
            if (tbl[i].ef[5]) chk($sformatf("v%0d inst_rdata", i), inst_rdata, tbl[i].rd);
            if (tbl[i].ef[4] && tbl[i].rv) chk($sformatf("v%0d data_rdata", i), data_rdata, tbl[i].rd);
        end

        // concurrent inst read and word write, then same-cycle R and B responses
        v = idle_v(); v.ireq = 1'b1; v.iaddr = 32'h1C00_0008; v.dreq = 1'b1; v.dwr = 1'b1; v.dsize = 2'd2;
        v.dstrb = 4'hF; v.daddr = 32'h400; v.dwdata = 32'hDEAD_BEEF;
        apply(v);
        chk_flags("conc accept", 8'b1100_0000);
        v = idle_v(); v.arrdy = 1'b1; v.awrdy = 1'b1; v.wrdy = 1'b1;
        apply(v);
        chk_flags("conc send", 8'b0000_1110);
        chk("conc araddr", araddr, 32'h1C00_0008);
        chk("conc awaddr", awaddr, 32'h400);
        chk("conc awsize", {29'd0, awsize}, 32'd2);
        chk("conc wstrb", {28'd0, wstrb}, 32'hF);
        chk("conc wdata", wdata, 32'hDEAD_BEEF);
        chk("tie wlast/awid/wid/arlen/arburst", {16'd0, wlast, awid, wid, arlen[2:0]},
            {16'd0, 1'b1, 4'd1, 4'd1, 3'd0});
        chk("tie arburst/rready", {29'd0, arburst, rready}, {29'd0, 2'b01, 1'b1});
        v = idle_v(); v.rv = 1'b1; v.rid = 4'd0; v.rd = 32'h4444_4444; v.bv = 1'b1;
        apply(v);
        chk_flags("dual resp", 8'b0011_0001);
        chk("dual inst_rdata", inst_rdata, 32'h4444_4444);
        v = idle_v();
        apply(v);
        chk_flags("dual after", 8'b0000_0000);

        // reset while the write is in W_SEND, then a clean inst read
        v = idle_v(); v.dreq = 1'b1; v.dwr = 1'b1; v.dsize = 2'd1; v.dstrb = 4'h3; v.daddr = 32'h500;
        v.dwdata = 32'h1234_5678;
        apply(v);
        chk_flags("rst wr accept", 8'b0100_0000);
        v = idle_v(); v.rst = 1'b1;
        apply(v);
        chk_flags("rst during send", 8'b0000_0110);
        v = idle_v();
        apply(v);
        chk_flags("rst after", 8'b0000_0000);
        chk("rst awaddr", awaddr, 32'd0);
        chk("rst wdata", wdata, 32'd0);
        v = idle_v(); v.ireq = 1'b1; v.iaddr = 32'h1C00_000C; v.arrdy = 1'b1;
        apply(v);
        chk_flags("post rst accept", 8'b1000_0000);
        v = idle_v(); v.arrdy = 1'b1;
        apply(v);
        chk_flags("post rst ar", 8'b0000_1000);
        chk("post rst araddr", araddr, 32'h1C00_000C);
        chk("post rst arsize", {29'd0, arsize}, 32'd2);
        v = idle_v(); v.rv = 1'b1; v.rid = 4'd0; v.rd = 32'h5555_5555;
        apply(v);
        chk_flags("post rst r", 8'b0010_0000);
        chk("post rst rdata", inst_rdata, 32'h5555_5555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
Converts the CPU's two request/response memory ports (instruction and data) into one AXI4 master port. It sits directly downstream of the CPU core top and connects to the AXI interconnect/RAM. It allows at most one outstanding read per source and one outstanding write. Read ID 0 belongs to instruction fetch, ID 1 to data.

Parameters:
DATA_ID, 1, AXI ID used for data reads and for all writes
INST_ID, 0, AXI ID used for instruction reads

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
inst_req  in  1  instruction read request
inst_addr  in  32  instruction byte address
inst_addr_ok  out  1  instruction request accepted this cycle
inst_data_ok  out  1  instruction read data valid this cycle
inst_rdata  out  32  instruction read data
data_req  in  1  data request
data_wr  in  1  1 = write, 0 = read
data_size  in  2  0 = byte, 1 = half, 2 = word
data_wstrb  in  4  byte enables for writes
data_addr  in  32  data byte address
data_wdata  in  32  write data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  read data valid, or write response received
data_rdata  out  32  data read data
arid  out  4  read ID
araddr  out  32  read address
arsize  out  3  {1'b0, size}
arvalid  out  1  read address valid
arready  in  1  read address ready
rid  in  4  read data ID
rdata  in  32  read data
rvalid  in  1  read data valid
rready  out  1  constant 1
awaddr  out  32  write address
awsize  out  3  {1'b0, data_size}
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  write data
wstrb  out  4  write strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bvalid  in  1  write response valid
bready  out  1  write response ready

Fixed AXI fields are tied off by the top: len=0, burst=INCR, lock/cache/prot=0, wlast=1, awid=wid=DATA_ID.

Behaviour:
- Reset (synchronous, active-high):
  - all state machines go IDLE and pending flags clear.
  - arvalid, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok are all 0.
  - AR/AW/W payload registers are 0.
  - A reset mid-transaction abandons it with no responses; the system reset also clears the slave.
- AR FSM has two states, AR_IDLE and AR_SEND.
  - In AR_IDLE, a request is accepted (addr_ok=1, combinational, same cycle) and its ID, address and size are latched. The next state is AR_SEND.
  - In AR_SEND, arvalid=1 and the payload is held stable until arready. On arvalid&arready the FSM returns to AR_IDLE.
- Read acceptance and arbitration:
  - Data read is accepted when data_req & ~data_wr & AR_IDLE & ~data_rd_pend & W FSM IDLE (no outstanding write; this gives read-after-write ordering).
  - Instruction read is accepted when inst_req & AR_IDLE & ~inst_rd_pend & no data read being accepted this cycle. Data has fixed priority over instruction.
  - Acceptance sets the source's rd_pend flag.
  - Instruction reads always have size = word.
- R channel:
  - rready is always 1.
  - On rvalid, rid==INST_ID drives inst_data_ok=1, inst_rdata=rdata and clears inst_rd_pend.
  - On rvalid, rid==DATA_ID drives data_data_ok=1, data_rdata=rdata and clears data_rd_pend.
  - This path is combinational, zero added latency. A response with an unmatched rid is dropped.
- W FSM has three states: W_IDLE, W_SEND and W_RESP.
  - W_IDLE: write accepted when data_req & data_wr & ~data_rd_pend & AR FSM not holding a data read. It latches addr, size, wstrb and wdata, asserts data_addr_ok, and moves to W_SEND with awvalid=wvalid=1.
  - W_SEND: awvalid drops on awready and wvalid drops on wready, independently; they may complete in the same or different cycles. When both are done the FSM moves to W_RESP.
  - W_RESP: bready=1. On bvalid, data_data_ok=1 for one cycle and the FSM returns to W_IDLE.
- A write's bvalid and a data-read rvalid cannot coincide, because data traffic is serialized.
- An instruction read and a data write may be outstanding simultaneously.
- A same-cycle inst R response and data B response is legal: both data_ok outputs pulse.
- A pending flag set and cleared in the same cycle resolves to clear only if the response belongs to the earlier request. Acceptance requires ~pend, so set and clear never target the same flag in one cycle.

Test Plan:
- Single inst read: inst_req, addr 0x1C000000, arready=1 -> addr_ok in cycle 0; arvalid, arid=0 in cycle 1; rvalid with rdata=0x02800C0C in cycle 3 -> inst_data_ok=1 and inst_rdata=0x02800C0C in cycle 3.
- Conflict: inst_req and data read (addr 0x100) in the same cycle -> data_addr_ok=1, inst_addr_ok=0; arid=1, araddr=0x100; inst accepted once AR_IDLE returns.
- Write: byte store, wstrb=0x4, addr 0x203, wdata=0x00AB0000; awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid after 3; bvalid then gives data_data_ok for exactly 1 cycle.
- RAW ordering: write outstanding, data read requested -> data_addr_ok held 0 until the cycle after the B handshake, then accepted.
- Out-of-order IDs: data read then inst read outstanding; return rid=0 first, then rid=1 -> inst_data_ok first, data_data_ok second, each with the correct rdata.
- Reset mid-op: assert reset during W_SEND -> next cycle awvalid=wvalid=0, FSMs IDLE; a new inst read works normally afterwards.
